// File: rtl/pq_op_sched_pkg.sv
// Shared types and constants for the P/Q operation scheduler.
// Holds the opcode and FSM state encodings plus the operation thresholds.
package pq_pkg;

  localparam int SEL_THRESH = 10;
  localparam int RNG_LO     = 10;
  localparam int RNG_HI     = 20;

  typedef enum logic [2:0] {
    OP_MUL3 = 3'd0,
    OP_SHR  = 3'd1,
    OP_ADD6 = 3'd2,
    OP_NAND = 3'd3,
    OP_ROT  = 3'd4,
    OP_WIN  = 3'd5,
    OP_SEL  = 3'd6,
    OP_CHK  = 3'd7
  } pq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_OUT  = 2'd2
  } pq_state_e;

endpackage

// File: rtl/pq_op_sched_if.sv
// Requester, result and status bundle of the P/Q scheduler.
// The slave modport is the scheduler side; master is the front-end/consumer side.
interface pq_op_sched_if #(
  parameter int OPW  = 5,
  parameter int RESW = 8,
  parameter int CNTW = 8
);
  logic            a_valid;
  logic            a_ready;
  logic [2:0]      a_op;
  logic [OPW-1:0]  a_p;
  logic [OPW-1:0]  a_q;
  logic            b_valid;
  logic            b_ready;
  logic [2:0]      b_op;
  logic [OPW-1:0]  b_p;
  logic [OPW-1:0]  b_q;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic            res_tag;
  logic [CNTW-1:0] done_cnt;

  modport slave (
    input  a_valid, a_op, a_p, a_q,
    input  b_valid, b_op, b_p, b_q,
    input  res_ready,
    output a_ready, b_ready,
    output res_valid, res_data, res_tag, done_cnt
  );

  modport master (
    output a_valid, a_op, a_p, a_q,
    output b_valid, b_op, b_p, b_q,
    output res_ready,
    input  a_ready, b_ready,
    input  res_valid, res_data, res_tag, done_cnt
  );
endinterface

// File: rtl/pq_op_sched_op_unit.sv
// Combinational P/Q operation unit: maps opcode and operands to a zero-extended result.
// Bit positions in the rotate/window ops assume OPW = 5.
module pq_op_unit
  import pq_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int RESW = 8
) (
  input  pq_op_e          op,
  input  logic [OPW-1:0]  p,
  input  logic [OPW-1:0]  q,
  output logic [RESW-1:0] res
);

  logic [OPW:0]     p_x2;
  logic [OPW-1:0]   nand_v;
  logic [OPW-1:0]   rot_v;
  logic [2*OPW-1:0] pq_cat;
  logic [5:0]       win_v;
  logic [OPW-1:0]   sel_v;
  logic             in_rng;

  assign p_x2   = {p, 1'b0};
  assign nand_v = ~(p & q);
  assign rot_v  = {p[2:0], p[4:3]};
  assign pq_cat = {p, q};
  assign win_v  = pq_cat[7:2];
  assign sel_v  = (p > OPW'(SEL_THRESH)) ? p : q;
  assign in_rng = (q >= OPW'(RNG_LO)) && (q <= OPW'(RNG_HI));

  always_comb begin
    res = '0;
    case (op)
      OP_MUL3: res = RESW'(p) + RESW'(p_x2);
      OP_SHR:  res = RESW'(q >> 1);
      OP_ADD6: res = RESW'(p) + RESW'(6);
      OP_NAND: res = RESW'(nand_v);
      OP_ROT:  res = RESW'(rot_v);
      OP_WIN:  res = RESW'(win_v);
      OP_SEL:  res = RESW'(sel_v);
      OP_CHK:  res = RESW'({^p, in_rng});
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/pq_op_sched.sv
// Round-robin scheduler sharing one registered P/Q operation unit between requesters A and B.
// Flow: IDLE (grant + latch) -> EXEC (compute + register) -> OUT (hold until consumed).
module pq_op_sched
  import pq_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int RESW = 8,
  parameter int CNTW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pq_op_sched_if.slave bus
);

  pq_state_e       state, state_nxt;
  logic            last_b;
  logic            grant_a, grant_b;
  logic            a_rdy, b_rdy;
  logic            req_hs, res_hs;

  pq_op_e          op_p0;
  logic [OPW-1:0]  p_p0, q_p0;
  logic            tag_p0;
  logic [RESW-1:0] unit_res;
  logic [RESW-1:0] res_data_p1;
  logic            res_tag_p1;
  logic [CNTW-1:0] done_cnt_q;

  // last_b=1 means B was served last, so A wins the next contested grant.
  assign grant_b = bus.b_valid && (!bus.a_valid || !last_b);
  assign grant_a = bus.a_valid && !grant_b;

  always_comb begin
    state_nxt = state;
    a_rdy     = 1'b0;
    b_rdy     = 1'b0;
    case (state)
      ST_IDLE: begin
        a_rdy = rst_n && grant_a;
        b_rdy = rst_n && grant_b;
        if (grant_a || grant_b) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_OUT;
      ST_OUT:  if (bus.res_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_hs = a_rdy || b_rdy;
  assign res_hs = (state == ST_OUT) && bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_b     <= 1'b1;
      done_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs) last_b <= b_rdy;
      if (res_hs) done_cnt_q <= done_cnt_q + CNTW'(1);
    end
  end

  // p0: operands of the granted requester, captured on the request handshake
  always_ff @(posedge clk) begin
    if (req_hs) begin
      op_p0  <= b_rdy ? pq_op_e'(bus.b_op) : pq_op_e'(bus.a_op);
      p_p0   <= b_rdy ? bus.b_p : bus.a_p;
      q_p0   <= b_rdy ? bus.b_q : bus.a_q;
      tag_p0 <= b_rdy;
    end
  end

  pq_op_unit #(
    .OPW  (OPW),
    .RESW (RESW)
  ) u_op_unit (
    .op  (op_p0),
    .p   (p_p0),
    .q   (q_p0),
    .res (unit_res)
  );

  // p1: registered result, held through OUT until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_p1 <= '0;
      res_tag_p1  <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_data_p1 <= unit_res;
      res_tag_p1  <= tag_p0;
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.res_valid = (state == ST_OUT);
  assign bus.res_data  = res_data_p1;
  assign bus.res_tag   = res_tag_p1;
  assign bus.done_cnt  = done_cnt_q;

endmodule

// File: doc/pq_op_sched.md
Name: pq_op_sched

Overview:
- Round-robin scheduler that shares one registered P/Q operation unit between two requesters (A, B).
- Each requester presents a 5-bit operand pair and a 3-bit opcode over a valid/ready handshake.
- The block arbitrates between them, executes one operation at a time, and returns an 8-bit result tagged with the requester ID over a valid/ready output.
- It sits between the operand-producing front-ends and any downstream consumer of the P/Q operations.

Parameters:
- OPW, 5, operand width of P and Q (the opcode table below is defined only for 5).
- RESW, 8, result width; all results are zero-extended to RESW.
- CNTW, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has an operation.
- a_ready  out  1  A's operation accepted this cycle.
- a_op  in  3  A opcode.
- a_p  in  OPW  A operand P.
- a_q  in  OPW  A operand Q.
- b_valid, b_ready, b_op, b_p, b_q: same as A, for requester B.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  RESW  result.
- res_tag  out  1  0 = result belongs to A, 1 = result belongs to B.
- done_cnt  out  CNTW  count of completed result handshakes; wraps modulo 2^CNTW.

Behaviour:
- Reset (asynchronous, active-low), while rst_n=0:
  - a_ready=0, b_ready=0, res_valid=0, res_data=0, res_tag=0, done_cnt=0.
  - FSM returns to IDLE; round-robin pointer set so that A has priority.
- FSM states: IDLE, EXEC, OUT.
- IDLE:
  - Combinationally grant one requester. If only one is valid, grant it. If both are valid, grant the one not served last.
  - Assert ready only to the granted requester, and only in IDLE.
  - On handshake, latch op/p/q/tag, update the round-robin pointer, and go to EXEC.
- EXEC (one cycle): compute the result from the latched operands, register res_data and res_tag, and go to OUT.
- OUT:
  - res_valid=1. res_data and res_tag are held stable until res_ready=1.
  - On the handshake, increment done_cnt, drop res_valid, and return to IDLE.
- Latency and throughput:
  - Request handshake in cycle N gives res_valid=1 at cycle N+2.
  - Minimum spacing is 3 cycles per operation. No request is accepted while in EXEC or OUT.
- Opcode table (P, Q unsigned; result zero-extended):
  - 0: P*3 (7-bit).
  - 1: Q>>1.
  - 2: P+6.
  - 3: bitwise ~(P&Q).
  - 4: rotate, {P[2:0],P[4:3]}.
  - 5: window, {P,Q}[7:2] (6-bit).
  - 6: P>10 ? P : Q.
  - 7: {6'b0, ^P, (Q>=10 && Q<=20)}, i.e. bit1 = parity of P, bit0 = Q in range.
- Boundary conditions:
  - Both requesters valid at the same time: strict alternation, no starvation. A requester that stays valid is served at most one grant later than the other.
  - A request valid is allowed to drop without a handshake; nothing is latched.
  - res_ready held high in OUT: completes in one cycle, and the next request can be accepted in the following cycle (IDLE).
  - done_cnt wraps from 2^CNTW-1 to 0.
  - Reset asserted during EXEC or OUT: the in-flight operation is discarded and res_valid falls immediately (asynchronously).
  - No X propagation: requester inputs are ignored when not granted.

Decomposition:
- Shared package pq_pkg holds:
  - the opcode enum: OP_MUL3, OP_SHR, OP_ADD6, OP_NAND, OP_ROT, OP_WIN, OP_SEL, OP_CHK;
  - the FSM state enum;
  - constants SEL_THRESH=10, RNG_LO=10, RNG_HI=20.
- One sub-module is natural: pq_op_unit, a purely combinational op/p/q-to-result block instanced once inside the scheduler. The arbiter and FSM stay in pq_op_sched.

Test Plan:
- After reset, A only: op=0, p=31 -> a_ready for 1 cycle; two cycles later res_valid=1, res_data=93, res_tag=0; done_cnt=1 after res_ready.
- A and B valid continuously from reset (A op=2 p=31; B op=4 p=5'b10011) -> results in order A(37), B(8'b0000_1110), A, B…; tags alternate 0, 1, 0, 1.
- Backpressure: res_ready=0 for 6 cycles in OUT -> res_data and res_tag stable, a_ready=b_ready=0 throughout; completes on the first cycle with res_ready=1.
- B op=7 with p=5'b10110 and q=20 -> res_data=8'h03. Same with q=21 -> 8'h02.
- Op=6 with p=10, q=7 -> 7. Op=6 with p=11 -> 11. Op=5 with p=5'b10101, q=5'b01100 -> 6'b101011.
- Reset pulse during EXEC -> res_valid stays 0, done_cnt=0, A has priority on the next simultaneous request. Separately, 256 completions -> done_cnt wraps to 0.
